// File: rtl/mat_pkg.sv
// Shared types and widths for the matrix-multiply scheduler.
package mat_pkg;

  localparam int ELEM_W      = 8;
  localparam int ACC_W       = 18;
  localparam int IDX_W       = 4;
  localparam int DIM_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Row-major flattening; DIM <= 4 keeps row*dim+col within IDX_W bits.
  function automatic logic [IDX_W-1:0] flat_idx(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col,
                                                input int dim);
    return row * IDX_W'(dim) + col;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: 8x8 unsigned product added into an 18-bit accumulator.
module mac_unit
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*ELEM_W-1:0] prod_s;
  logic [ACC_W-1:0]    acc_r;

  assign prod_s = a * b;

  // Accumulator register; clear restarts the sum at the first product of an element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (enable) begin
      acc_r <= (clear ? '0 : acc_r) + ACC_W'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/mac_scheduler.sv
// Sequences C = A x B one dot product at a time over external element stores.
// Optional MAC_SCHED_ABORT_EN adds an abort input that cancels a run in progress.
module mac_scheduler
  import mat_pkg::*;
#(
  parameter int DIM = DIM_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MAC_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic [IDX_W-1:0]  a_idx,
  output logic [IDX_W-1:0]  b_idx,
  input  logic [ELEM_W-1:0] a_elem,
  input  logic [ELEM_W-1:0] b_elem,
  output logic              c_we,
  output logic [IDX_W-1:0]  c_idx,
  output logic [ACC_W-1:0]  c_data,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t             state_r;
  logic [IDX_W-1:0]   i_r, j_r, k_r;
  logic [IDX_W-1:0]   a_idx_r, b_idx_r, c_idx_r;
  logic               c_we_r, busy_r, done_r;
  logic               abort_hit_s;
  logic               c_we_s;
  logic [ACC_W-1:0]   acc_s;

`ifdef MAC_SCHED_ABORT_EN
  assign abort_hit_s = abort && ((state_r == ST_MAC) || (state_r == ST_WRITE));
  assign c_we_s      = c_we_r && !abort;
`else
  assign abort_hit_s = 1'b0;
  assign c_we_s      = c_we_r;
`endif

  mac_unit u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (k_r == '0),
    .enable (state_r == ST_MAC),
    .a      (a_elem),
    .b      (b_elem),
    .acc    (acc_s)
  );

  // Control FSM; indices and strobes are registered for the cycle they apply to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      a_idx_r <= '0;
      b_idx_r <= '0;
      c_idx_r <= '0;
      c_we_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (abort_hit_s) begin
      state_r <= ST_IDLE;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      a_idx_r <= '0;
      b_idx_r <= '0;
      c_idx_r <= '0;
      c_we_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      c_we_r  <= 1'b0;
      c_idx_r <= '0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          a_idx_r <= '0;
          b_idx_r <= '0;
          if (start) begin
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_MAC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_MAC: begin
          if (k_r == LAST) begin
            k_r     <= '0;
            a_idx_r <= '0;
            b_idx_r <= '0;
            c_we_r  <= 1'b1;
            c_idx_r <= flat_idx(i_r, j_r, DIM);
            state_r <= ST_WRITE;
          end else begin
            k_r     <= k_r + IDX_ONE;
            a_idx_r <= flat_idx(i_r, k_r + IDX_ONE, DIM);
            b_idx_r <= flat_idx(k_r + IDX_ONE, j_r, DIM);
            state_r <= ST_MAC;
          end
        end
        ST_WRITE: begin
          k_r <= '0;
          if ((i_r == LAST) && (j_r == LAST)) begin
            i_r     <= '0;
            j_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (j_r == LAST) begin
            i_r     <= i_r + IDX_ONE;
            j_r     <= '0;
            a_idx_r <= flat_idx(i_r + IDX_ONE, '0, DIM);
            b_idx_r <= '0;
            state_r <= ST_MAC;
          end else begin
            j_r     <= j_r + IDX_ONE;
            a_idx_r <= flat_idx(i_r, '0, DIM);
            b_idx_r <= j_r + IDX_ONE;
            state_r <= ST_MAC;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          a_idx_r <= '0;
          b_idx_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_idx  = a_idx_r;
  assign b_idx  = b_idx_r;
  assign c_we   = c_we_s;
  assign c_idx  = c_idx_r;
  assign c_data = c_we_s ? acc_s : '0;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler at DIM=3 and DIM=2; abort scenario only with MAC_SCHED_ABORT_EN.
module tb_mac_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start3, start2;
  logic [3:0]  a_idx3, b_idx3, c_idx3, a_idx2, b_idx2, c_idx2;
  logic [7:0]  a_elem3, b_elem3, a_elem2, b_elem2;
  logic        c_we3, busy3, done3, c_we2, busy2, done2;
  logic [17:0] c_data3, c_data2;
`ifdef MAC_SCHED_ABORT_EN
  logic        abort3;
`endif

  logic [7:0] a3 [16];
  logic [7:0] b3 [16];
  logic [7:0] a2 [16];
  logic [7:0] b2 [16];

  int checks = 0;
  int errors = 0;

  assign a_elem3 = a3[a_idx3];
  assign b_elem3 = b3[b_idx3];
  assign a_elem2 = a2[a_idx2];
  assign b_elem2 = b2[b_idx2];

  mac_scheduler #(.DIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef MAC_SCHED_ABORT_EN
    .abort(abort3),
`endif
    .a_idx(a_idx3), .b_idx(b_idx3), .a_elem(a_elem3), .b_elem(b_elem3),
    .c_we(c_we3), .c_idx(c_idx3), .c_data(c_data3), .busy(busy3), .done(done3)
  );

  mac_scheduler #(.DIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef MAC_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .a_idx(a_idx2), .b_idx(b_idx2), .a_elem(a_elem2), .b_elem(b_elem2),
    .c_we(c_we2), .c_idx(c_idx2), .c_data(c_data2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    start3 = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
  endtask

  task automatic load_identity();
    for (int n = 0; n < 16; n++) begin
      a3[n] = 8'd0;
      b3[n] = 8'(n + 1);
    end
    a3[0] = 8'd1; a3[4] = 8'd1; a3[8] = 8'd1;
  endtask

  task automatic pulse_start3();
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  task automatic test_reset();
    start3 = 1'b0; start2 = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    checks++;
    if ({busy3, done3, c_we3} !== 3'b000) begin
      errors++; $display("FAIL reset_flags3 got busy/done/we=%b want 000", {busy3, done3, c_we3});
    end
    checks++;
    if ({a_idx3, b_idx3, c_idx3, c_data3} !== 30'd0) begin
      errors++; $display("FAIL reset_data3 got a=%0d b=%0d c=%0d d=%0d want all 0", a_idx3, b_idx3, c_idx3, c_data3);
    end
    checks++;
    if ({busy2, done2, c_we2, a_idx2, b_idx2, c_idx2, c_data2} !== 33'd0) begin
      errors++; $display("FAIL reset_dim2 got busy=%0b done=%0b we=%0b d=%0d want all 0", busy2, done2, c_we2, c_data2);
    end
  endtask

  task automatic test_identity();
    int writes = 0;
    load_identity();
    reset_dut();
    pulse_start3();
    for (int cyc = 1; cyc <= 38; cyc++) begin
      checks++;
      if ((cyc % 4 == 0) && (cyc <= 36)) begin
        if (c_we3 !== 1'b1 || c_idx3 !== 4'(cyc / 4 - 1) || c_data3 !== 18'(cyc / 4)) begin
          errors++; $display("FAIL ident_write cyc=%0d got we=%0b idx=%0d data=%0d want we=1 idx=%0d data=%0d",
                             cyc, c_we3, c_idx3, c_data3, cyc / 4 - 1, cyc / 4);
        end
      end else if (c_we3 !== 1'b0 || c_data3 !== 18'd0) begin
        errors++; $display("FAIL ident_idle_we cyc=%0d got we=%0b data=%0d want 0", cyc, c_we3, c_data3);
      end
      checks++;
      if (done3 !== (cyc == 37)) begin
        errors++; $display("FAIL ident_done cyc=%0d got %0b want %0b", cyc, done3, cyc == 37);
      end
      checks++;
      if (busy3 !== (cyc <= 36)) begin
        errors++; $display("FAIL ident_busy cyc=%0d got %0b want %0b", cyc, busy3, cyc <= 36);
      end
      if (cyc == 6) begin
        checks++;
        if (a_idx3 !== 4'd1 || b_idx3 !== 4'd4) begin
          errors++; $display("FAIL ident_idx cyc=6 got a=%0d b=%0d want a=1 b=4", a_idx3, b_idx3);
        end
      end
      if (c_we3 === 1'b1) writes++;
      @(posedge clk); #1;
    end
    checks++;
    if (writes != 9) begin
      errors++; $display("FAIL ident_count got %0d want 9", writes);
    end
    checks++;
    if (a_idx3 !== 4'd0 || b_idx3 !== 4'd0) begin
      errors++; $display("FAIL ident_idle_idx got a=%0d b=%0d want 0", a_idx3, b_idx3);
    end
  endtask

  task automatic test_max_values();
    for (int n = 0; n < 16; n++) begin
      a3[n] = 8'd255;
      b3[n] = 8'd255;
    end
    reset_dut();
    pulse_start3();
    for (int cyc = 1; cyc <= 37; cyc++) begin
      if ((cyc % 4 == 0) && (cyc <= 36)) begin
        checks++;
        if (c_we3 !== 1'b1 || c_idx3 !== 4'(cyc / 4 - 1) || c_data3 !== 18'd195075) begin
          errors++; $display("FAIL max_write cyc=%0d got we=%0b idx=%0d data=%0d want we=1 idx=%0d data=195075",
                             cyc, c_we3, c_idx3, c_data3, cyc / 4 - 1);
        end
      end
      if (cyc == 37) begin
        checks++;
        if (done3 !== 1'b1) begin
          errors++; $display("FAIL max_done got %0b want 1", done3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_held();
    int writes = 0;
    load_identity();
    reset_dut();
    start3 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 39; cyc++) begin
      if (cyc <= 38 && c_we3 === 1'b1) begin
        writes++;
        checks++;
        if (c_idx3 !== 4'(writes - 1)) begin
          errors++; $display("FAIL held_order cyc=%0d got idx=%0d want %0d", cyc, c_idx3, writes - 1);
        end
      end
      if (cyc == 37) begin
        checks++;
        if (done3 !== 1'b1) begin
          errors++; $display("FAIL held_done got %0b want 1", done3);
        end
      end
      if (cyc == 38) begin
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0) begin
          errors++; $display("FAIL held_idle got busy=%0b done=%0b want 0 0", busy3, done3);
        end
      end
      if (cyc == 39) begin
        checks++;
        if (busy3 !== 1'b1) begin
          errors++; $display("FAIL held_restart got busy=%0b want 1", busy3);
        end
      end
      @(posedge clk); #1;
    end
    start3 = 1'b0;
    checks++;
    if (writes != 9) begin
      errors++; $display("FAIL held_count got %0d want 9", writes);
    end
  endtask

  task automatic test_reset_midrun();
    load_identity();
    reset_dut();
    pulse_start3();
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc >= 11) begin
        checks++;
        if (busy3 !== 1'b0 || c_we3 !== 1'b0 || done3 !== 1'b0) begin
          errors++; $display("FAIL midrst_quiet cyc=%0d got busy=%0b we=%0b done=%0b want 0 0 0", cyc, busy3, c_we3, done3);
        end
      end
      if (cyc == 10) rst_n = 1'b0;
      if (cyc == 11) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    pulse_start3();
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc == 4) begin
        checks++;
        if (c_we3 !== 1'b1 || c_idx3 !== 4'd0 || c_data3 !== 18'd1) begin
          errors++; $display("FAIL midrst_restart got we=%0b idx=%0d data=%0d want 1 0 1", c_we3, c_idx3, c_data3);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dim2();
    logic [17:0] exp_c [4];
    exp_c = '{18'd19, 18'd22, 18'd43, 18'd50};
    for (int n = 0; n < 16; n++) begin
      a2[n] = 8'd0;
      b2[n] = 8'd0;
    end
    a2[0] = 8'd1; a2[1] = 8'd2; a2[2] = 8'd3; a2[3] = 8'd4;
    b2[0] = 8'd5; b2[1] = 8'd6; b2[2] = 8'd7; b2[3] = 8'd8;
    reset_dut();
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      checks++;
      if ((cyc % 3 == 0) && (cyc <= 12)) begin
        if (c_we2 !== 1'b1 || c_idx2 !== 4'(cyc / 3 - 1) || c_data2 !== exp_c[cyc / 3 - 1]) begin
          errors++; $display("FAIL dim2_write cyc=%0d got we=%0b idx=%0d data=%0d want we=1 idx=%0d data=%0d",
                             cyc, c_we2, c_idx2, c_data2, cyc / 3 - 1, exp_c[cyc / 3 - 1]);
        end
      end else if (c_we2 !== 1'b0) begin
        errors++; $display("FAIL dim2_we cyc=%0d got %0b want 0", cyc, c_we2);
      end
      checks++;
      if (done2 !== (cyc == 13)) begin
        errors++; $display("FAIL dim2_done cyc=%0d got %0b want %0b", cyc, done2, cyc == 13);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef MAC_SCHED_ABORT_EN
  task automatic test_abort();
    load_identity();
    reset_dut();
    abort3 = 1'b0;
    pulse_start3();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 4) begin
        checks++;
        if (c_we3 !== 1'b1 || c_idx3 !== 4'd0) begin
          errors++; $display("FAIL abort_first got we=%0b idx=%0d want 1 0", c_we3, c_idx3);
        end
      end
      if (cyc >= 5) begin
        checks++;
        if (c_we3 !== 1'b0 || done3 !== 1'b0 || (cyc >= 7 && busy3 !== 1'b0)) begin
          errors++; $display("FAIL abort_quiet cyc=%0d got we=%0b done=%0b busy=%0b", cyc, c_we3, done3, busy3);
        end
      end
      if (cyc == 6) abort3 = 1'b1;
      if (cyc == 7) abort3 = 1'b0;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    start3 = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b0;
`ifdef MAC_SCHED_ABORT_EN
    abort3 = 1'b0;
`endif
    for (int n = 0; n < 16; n++) begin
      a3[n] = 8'd0; b3[n] = 8'd0; a2[n] = 8'd0; b2[n] = 8'd0;
    end
    #1;
    test_reset();
    test_identity();
    test_max_values();
    test_start_held();
    test_reset_midrun();
    test_dim2();
`ifdef MAC_SCHED_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
